// File: rtl/cell_reader_pkg.sv
// Shared types and constants for the per-cell position reader.
package cell_reader_pkg;

  localparam int POS_COMP_WIDTH      = 32;
  localparam int COUNT_ADDR          = 0;
  localparam int FIRST_PARTICLE_ADDR = 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_CNT,
    WAIT_CNT,
    STREAM,
    DRAIN,
    FIN
  } state_t;

endpackage

// File: rtl/pos_stream_fifo.sv
// Small synchronous FIFO holding {last, pid, position} beats for the output stream.
// A push is accepted at full when a pop happens in the same cycle.
module pos_stream_fifo #(
  parameter int WIDTH = 105,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = store[rd_ptr];

  // Storage write; contents need no reset because emptiness is tracked by count.
  always_ff @(posedge clock) begin
    if (do_push) store[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/cell_pos_reader.sv
// Read-side sequencer for one cell position memory: reads the particle count
// at address 0, then streams particles 1..count through a credit-managed FIFO
// that absorbs the memory's fixed read latency.
module cell_pos_reader
  import cell_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int RD_LATENCY   = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_last
);

  localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int WAIT_W  = $clog2(RD_LATENCY + 1);
  localparam int CRED_W  = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;

  localparam logic [ADDR_WIDTH-1:0] MAX_PID    = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(FIRST_PARTICLE_ADDR);
  localparam logic [WAIT_W-1:0]     LAST_WAIT  = WAIT_W'(RD_LATENCY - 1);

  state_t                  state;
  logic [WAIT_W-1:0]       wait_cnt;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic                    issue_vld;
  logic                    issue_last;

  logic                    pipe_vld  [RD_LATENCY];
  logic [ADDR_WIDTH-1:0]   pipe_pid  [RD_LATENCY];
  logic                    pipe_last [RD_LATENCY];

  logic [ENTRY_W-1:0]      fifo_wdata;
  logic [ENTRY_W-1:0]      fifo_rdata;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic                    pop;

  logic [DATA_WIDTH-1:0]   head_data;
  logic [ADDR_WIDTH-1:0]   head_pid;
  logic                    head_last;

  logic [ADDR_WIDTH-1:0]   count_raw;
  logic [ADDR_WIDTH-1:0]   count_clamped;
  logic [CRED_W-1:0]       outstanding;
  logic                    can_issue;

  assign mem_wren = 1'b0;
  assign mem_data = '0;

  // Count word beyond the last legal particle address is clamped to it.
  assign count_raw     = mem_q[ADDR_WIDTH-1:0];
  assign count_clamped = (count_raw > MAX_PID) ? MAX_PID : count_raw;

  // Output stream comes straight from the FIFO head; zeroed while empty.
  assign {head_last, head_pid, head_data} = fifo_rdata;
  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_empty ? '0 : head_data;
  assign out_pid   = fifo_empty ? '0 : head_pid;
  assign out_last  = ~fifo_empty & head_last;
  assign pop       = out_valid & out_ready;

  // Everything already committed to the FIFO: stored beats plus reads in flight.
  // A pop this cycle frees one slot for the read issued on the next cycle.
  always_comb begin
    outstanding = CRED_W'(fifo_count) + CRED_W'(issue_vld);
    for (int i = 0; i < RD_LATENCY; i++) begin
      outstanding = outstanding + CRED_W'(pipe_vld[i]);
    end
    can_issue = (outstanding - CRED_W'(pop)) < CRED_W'(FIFO_DEPTH);
  end

  // Tag valid bits shadow the memory latency so each tag meets its own read data.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) pipe_vld[i] <= 1'b0;
    end else begin
      pipe_vld[0] <= issue_vld;
      for (int i = 1; i < RD_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  // Tag payload (pid, last flag) travels alongside the valid bits.
  always_ff @(posedge clock) begin
    pipe_pid[0]  <= mem_address;
    pipe_last[0] <= issue_last;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_pid[i]  <= pipe_pid[i-1];
      pipe_last[i] <= pipe_last[i-1];
    end
  end

  assign fifo_wdata = {pipe_last[RD_LATENCY-1], pipe_pid[RD_LATENCY-1], mem_q};

  pos_stream_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .rst_n (rst_n),
    .push  (pipe_vld[RD_LATENCY-1]),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sequencer: count read, latency wait, credit-limited particle issue, drain.
  // Memory controls are registered, so each branch sets up next cycle's read.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      particle_count <= '0;
      mem_address    <= '0;
      mem_rden       <= 1'b0;
      issue_vld      <= 1'b0;
      issue_last     <= 1'b0;
      next_addr      <= '0;
      wait_cnt       <= '0;
    end else begin
      done       <= 1'b0;
      mem_rden   <= 1'b0;
      issue_vld  <= 1'b0;
      issue_last <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RD_CNT;
            busy        <= 1'b1;
            mem_rden    <= 1'b1;
            mem_address <= ADDR_WIDTH'(COUNT_ADDR);
          end
        end
        RD_CNT: begin
          state    <= WAIT_CNT;
          wait_cnt <= '0;
        end
        WAIT_CNT: begin
          if (wait_cnt == LAST_WAIT) begin
            particle_count <= count_clamped;
            if (count_clamped == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state       <= STREAM;
              mem_rden    <= 1'b1;
              issue_vld   <= 1'b1;
              mem_address <= FIRST_ADDR;
              issue_last  <= (count_clamped == FIRST_ADDR);
              next_addr   <= FIRST_ADDR + ADDR_WIDTH'(1);
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        STREAM: begin
          if (issue_vld && (mem_address == particle_count)) begin
            state <= DRAIN;
          end else if (can_issue) begin
            mem_rden    <= 1'b1;
            issue_vld   <= 1'b1;
            mem_address <= next_addr;
            issue_last  <= (next_addr == particle_count);
            next_addr   <= next_addr + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_pos_reader.sv
// Directed bench for cell_pos_reader with a 2-cycle-latency memory model.
module tb_cell_pos_reader;
  import cell_reader_pkg::*;

  localparam int DW = 96;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] particle_count;
  logic [AW-1:0] mem_address;
  logic          mem_rden;
  logic          mem_wren;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_q = '0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_pid;
  logic          out_last;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cell_pos_reader #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .PARTICLE_NUM (220),
    .RD_LATENCY   (2),
    .FIFO_DEPTH   (4)
  ) dut (
    .clock          (clock),
    .rst_n          (rst_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .particle_count (particle_count),
    .mem_address    (mem_address),
    .mem_rden       (mem_rden),
    .mem_wren       (mem_wren),
    .mem_data       (mem_data),
    .mem_q          (mem_q),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_pid        (out_pid),
    .out_last       (out_last)
  );

  // Memory model: data appears two cycles after the cycle rden is high.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] q_p1 = '0;
  always @(posedge clock) begin
    q_p1  <= mem_rden ? mem[mem_address] : '0;
    mem_q <= q_p1;
  end

  function automatic logic [DW-1:0] pat(input int a);
    logic [POS_COMP_WIDTH-1:0] x, y, z;
    x = 32'(a) * 32'h0000_9E37 + 32'h11;
    y = ~32'(a);
    z = 32'(a) ^ 32'hA5A5_5A5A;
    return {z, y, x};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one cell from the start pulse (cycle t=0) to a few cycles past done.
  task automatic run_cell(input logic [DW-1:0] word, input int exp_cnt, input int mode,
                          input bit poke, input bit timed, input string tag);
    int nexp = 1, first = -1, done_at = -1, ndone = 0, reads0 = 0, maxaddr = 0;
    int issued = 0, accepted = 0, over = 0, unstable = 0;
    bit stall_prev = 1'b0;
    logic [DW-1:0] pd = '0;
    logic [AW-1:0] pp = '0;
    logic pl = 1'b0;
    mem[0] = word;
    for (int t = 0; t < 700; t++) begin
      @(negedge clock);
      start     = (t == 0) || (poke && (t == 3 || t == 8));
      out_ready = (mode == 0) ? 1'b1 : ((t % 4 == 0) || (t % 4 == 3));
      if (mem_rden) begin
        if (mem_address == '0) reads0++;
        else issued++;
        if (int'(mem_address) > maxaddr) maxaddr = int'(mem_address);
      end
      if (issued - accepted > 4) over++;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = t;
      end
      if (stall_prev && (!out_valid || out_data !== pd || out_pid !== pp || out_last !== pl))
        unstable++;
      if (out_valid) begin
        if (first < 0) first = t;
        if (out_ready) begin
          chk({tag, "_pid"}, 128'(out_pid), 128'(nexp));
          chk({tag, "_data"}, 128'(out_data), 128'(pat(nexp)));
          chk({tag, "_last"}, 128'(out_last), 128'(nexp == exp_cnt));
          nexp++;
          accepted++;
        end
      end
      stall_prev = out_valid && !out_ready;
      pd = out_data;
      pp = out_pid;
      pl = out_last;
      if (done_at >= 0 && t >= done_at + 3) break;
    end
    start = 1'b0;
    chk({tag, "_beats"}, 128'(nexp - 1), 128'(exp_cnt));
    chk({tag, "_count"}, 128'(particle_count), 128'(exp_cnt));
    chk({tag, "_ndone"}, 128'(ndone), 128'(1));
    chk({tag, "_addr0_reads"}, 128'(reads0), 128'(1));
    chk({tag, "_max_addr"}, 128'(maxaddr), 128'(exp_cnt));
    chk({tag, "_credit_over"}, 128'(over), 128'(0));
    chk({tag, "_stall_unstable"}, 128'(unstable), 128'(0));
    chk({tag, "_busy_end"}, 128'(busy), 128'(0));
    if (timed) begin
      chk({tag, "_first_valid_t"}, 128'(first), 128'((exp_cnt == 0) ? -1 : 7));
      chk({tag, "_done_t"}, 128'(done_at), 128'((exp_cnt == 0) ? 4 : 7 + exp_cnt));
    end
  endtask

  typedef struct {
    logic [DW-1:0] word;
    int            exp_cnt;
    int            mode;
    bit            poke;
    bit            timed;
    string         tag;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{96'd3,                    3,   0, 1'b0, 1'b1, "cnt3"};
    vecs[1] = '{96'd0,                    0,   0, 1'b0, 1'b1, "cnt0"};
    vecs[2] = '{96'd5,                    5,   1, 1'b0, 1'b0, "cnt5_bp"};
    vecs[3] = '{96'd250,                  219, 0, 1'b0, 1'b1, "clamp250"};
    vecs[4] = '{96'd4,                    4,   0, 1'b1, 1'b1, "busy_start"};
    vecs[5] = '{{88'h1234_5678, 8'd2},    2,   1, 1'b0, 1'b0, "hibits"};

    for (int i = 1; i < 256; i++) mem[i] = pat(i);
    mem[0]    = '0;
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clock);

    chk("rst_busy",  128'(busy), 128'(0));
    chk("rst_done",  128'(done), 128'(0));
    chk("rst_count", 128'(particle_count), 128'(0));
    chk("rst_addr",  128'(mem_address), 128'(0));
    chk("rst_rden",  128'(mem_rden), 128'(0));
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_data",  128'(out_data), 128'(0));
    chk("rst_pid",   128'(out_pid), 128'(0));
    chk("rst_last",  128'(out_last), 128'(0));
    chk("rst_wren",  128'(mem_wren), 128'(0));
    chk("rst_mdata", 128'(mem_data), 128'(0));
    rst_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      run_cell(vecs[i].word, vecs[i].exp_cnt, vecs[i].mode, vecs[i].poke, vecs[i].timed, vecs[i].tag);
    end

    // Reset in the middle of streaming a 10-particle cell, reads in flight.
    mem[0] = 96'd10;
    @(negedge clock);
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    chk("midrst_pre_busy", 128'(busy), 128'(1));
    chk("midrst_pre_rden", 128'(mem_rden), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",  128'(busy), 128'(0));
    chk("midrst_done",  128'(done), 128'(0));
    chk("midrst_count", 128'(particle_count), 128'(0));
    chk("midrst_addr",  128'(mem_address), 128'(0));
    chk("midrst_rden",  128'(mem_rden), 128'(0));
    chk("midrst_valid", 128'(out_valid), 128'(0));
    chk("midrst_data",  128'(out_data), 128'(0));
    chk("midrst_pid",   128'(out_pid), 128'(0));
    chk("midrst_last",  128'(out_last), 128'(0));
    begin
      int dseen = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clock);
        if (done || out_valid) dseen++;
      end
      chk("midrst_quiet", 128'(dseen), 128'(0));
    end
    rst_n = 1'b1;
    @(negedge clock);
    run_cell(96'd3, 3, 0, 1'b0, 1'b1, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
